// File: rtl/char_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : char_in_pkg                                                        |
// | Brief  : Register map, bit positions and CTRL type for char_in_ctrl.        |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package char_in_pkg;

  localparam logic [3:0] DATA_OFS = 4'h0;
  localparam logic [3:0] STAT_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS = 4'h8;

  localparam int STAT_NE_BIT   = 0;
  localparam int STAT_OVF_BIT  = 1;
  localparam int STAT_CNT_LSB  = 8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IE_BIT    = 1;
  localparam int CTRL_FLUSH_BIT = 2;

  typedef struct packed {
    logic ie;
    logic en;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : char_fifo                                                          |
// | Brief  : 8-bit first-word-fall-through FIFO with flush and occupancy count. |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module char_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign w_do_pop  = pop & ~empty & ~flush;
  assign w_do_push = push & ~flush & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/char_in_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : char_in_ctrl                                                       |
// | Brief  : Keyboard char/strobe receive FIFO with DATA/STAT/CTRL bus regs.    |
// |          Define CHAR_IN_IRQ_EN to build the level interrupt and CTRL.IE.    |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module char_in_ctrl
  import char_in_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic        strobe,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             w_empty;
  logic             w_full;
  logic [7:0]       w_dout;
  logic [CNT_W-1:0] w_count;
  logic [3:0]       w_reg;
  logic             w_rd;
  logic             w_wr;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  ctrl_t            r_ctrl;
  logic             r_ovf;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

  assign gnt    = req;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

  assign w_reg = {addr[3:2], 2'b00};
  assign w_rd  = req & ~we;
  assign w_wr  = req & we;

  assign w_pop     = w_rd & (w_reg == DATA_OFS) & ~w_empty;
  assign w_flush   = w_wr & (w_reg == CTRL_OFS) & wdata[CTRL_FLUSH_BIT];
  assign w_push    = strobe & r_ctrl.en & ~w_flush;
  // Dropped only when no slot opens this cycle; a flush discards silently.
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = w_wr & (w_reg == STAT_OFS) & wdata[STAT_OVF_BIT];

  assign w_unused_bits = &{1'b0, wdata[31:3], addr[1:0]};

  char_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (char),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_reg)
        DATA_OFS: begin
          if (!w_empty) w_rdata[7:0] = w_dout;
        end
        STAT_OFS: begin
          w_rdata[STAT_CNT_LSB +: 8] = 8'(w_count);
          w_rdata[STAT_OVF_BIT]      = r_ovf;
          w_rdata[STAT_NE_BIT]       = ~w_empty;
        end
        CTRL_OFS: begin
          w_rdata[CTRL_EN_BIT] = r_ctrl.en;
          w_rdata[CTRL_IE_BIT] = r_ctrl.ie;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_ovf    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req;
      r_rdata  <= w_rdata;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && (w_reg == CTRL_OFS)) begin
        r_ctrl.en <= wdata[CTRL_EN_BIT];
`ifdef CHAR_IN_IRQ_EN
        r_ctrl.ie <= wdata[CTRL_IE_BIT];
`else
        r_ctrl.ie <= 1'b0;
`endif
      end
    end
  end

`ifdef CHAR_IN_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl.ie & (~w_empty | r_ovf);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire
